fir_core: RTL and testbench



---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_coef_rom.sv | 11 +
 rtl/fir_core.sv | 98 +++++++++
 tb/tb_fir_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and default coefficient set for the FIR core.
// Coefficients: 32-tap Hamming-windowed low-pass, fc = 4 kHz at fs = 44.1 kHz, Q15.
package fir_pkg;

   localparam int unsigned NTAPS = 32;
   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = $clog2(NTAPS);
   localparam int unsigned ACCW  = 2*DW + AW;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   // Centre pair differs by one LSB so the taps sum to exactly 32767 (unity DC gain).
   localparam logic signed [DW-1:0] COEF [0:NTAPS-1] = '{
       16'sd29,    16'sd59,    16'sd88,    16'sd101,   16'sd56,   -16'sd85,   -16'sd317,  -16'sd572,
      -16'sd706,  -16'sd555,   16'sd10,    16'sd1036,  16'sd2408,  16'sd3878,  16'sd5119,  16'sd5835,
       16'sd5834,  16'sd5119,  16'sd3878,  16'sd2408,  16'sd1036,  16'sd10,   -16'sd555,  -16'sd706,
      -16'sd572,  -16'sd317,  -16'sd85,    16'sd56,    16'sd101,   16'sd88,    16'sd59,    16'sd29
   };

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup: tap index -> signed Q15 coefficient.
module fir_coef_rom
   import fir_pkg::*;
(
   input  logic [AW-1:0]        addr,
   output logic signed [DW-1:0] coef_c
);

   assign coef_c = COEF[addr];

endmodule

// File: rtl/fir_core.sv
// Time-multiplexed FIR filter: one MAC stepped over NTAPS taps per accepted sample,
// followed by Q15 round-half-up and saturation to 16 bits.
module fir_core #(
   parameter int unsigned NTAPS = fir_pkg::NTAPS,
   parameter int unsigned DW    = fir_pkg::DW,
   parameter int unsigned ACCW  = 2*DW + $clog2(NTAPS)
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          s_axis_data_tvalid,
   output logic          s_axis_data_tready,
   input  logic [DW-1:0] s_axis_data_tdata,
   output logic          m_axis_data_tvalid,
   output logic [DW-1:0] m_axis_data_tdata
);
   import fir_pkg::*;

   localparam int unsigned IDXW = $clog2(NTAPS);
   localparam logic signed [ACCW-1:0] RND     = ACCW'(2**(DW-2));
   localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2**(DW-1)) - 1);
   localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

   state_t                 state;
   logic [IDXW-1:0]        idx;
   logic signed [ACCW-1:0] acc;
   logic signed [DW-1:0]   x [0:NTAPS-1];

   logic signed [DW-1:0]   coef_c;
   logic signed [2*DW-1:0] prod_c;
   logic signed [ACCW-1:0] acc_shr_c;
   logic [DW-1:0]          sat_c;

   fir_coef_rom u_rom (
      .addr   (idx),
      .coef_c (coef_c)
   );

   // Full-precision product, then round-half-up and clamp to the Q15 range.
   always_comb begin
      prod_c    = coef_c * x[idx];
      acc_shr_c = (acc + RND) >>> (DW-1);
      sat_c     = acc_shr_c[DW-1:0];
      if (acc_shr_c > SAT_MAX) begin
         sat_c = {1'b0, {(DW-1){1'b1}}};
      end else if (acc_shr_c < SAT_MIN) begin
         sat_c = {1'b1, {(DW-1){1'b0}}};
      end
   end

   // Sequencer, delay line and MAC accumulator.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state              <= IDLE;
         idx                <= '0;
         acc                <= '0;
         s_axis_data_tready <= 1'b1;
         m_axis_data_tvalid <= 1'b0;
         m_axis_data_tdata  <= '0;
         for (int k = 0; k < int'(NTAPS); k++) begin
            x[k] <= '0;
         end
      end else begin
         m_axis_data_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (s_axis_data_tvalid) begin
                  x[0] <= s_axis_data_tdata;
                  for (int k = 1; k < int'(NTAPS); k++) begin
                     x[k] <= x[k-1];
                  end
                  acc                <= '0;
                  idx                <= '0;
                  s_axis_data_tready <= 1'b0;
                  state              <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACCW'(prod_c);
               idx <= idx + 1'b1;
               if (idx == IDXW'(NTAPS-1)) begin
                  state <= OUT;
               end
            end
            OUT: begin
               // tready rises with the result so the next sample lands NTAPS+2 edges after the last.
               m_axis_data_tdata  <= sat_c;
               m_axis_data_tvalid <= 1'b1;
               s_axis_data_tready <= 1'b1;
               state              <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_core.sv
// Directed and random bench for fir_core: scoreboard fed at accept time, drained by an output monitor.
module tb_fir_core;
   import fir_pkg::*;

   localparam int NT = int'(fir_pkg::NTAPS);

   typedef struct {
      logic [15:0] data;
      int          edge_n;
   } exp_t;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_axis_data_tvalid;
   logic        s_axis_data_tready;
   logic [15:0] s_axis_data_tdata;
   logic        m_axis_data_tvalid;
   logic [15:0] m_axis_data_tdata;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb [$];
   logic signed [15:0] hist [NT];

   fir_core dut (
      .aclk               (aclk),
      .areset             (areset),
      .s_axis_data_tvalid (s_axis_data_tvalid),
      .s_axis_data_tready (s_axis_data_tready),
      .s_axis_data_tdata  (s_axis_data_tdata),
      .m_axis_data_tvalid (m_axis_data_tvalid),
      .m_axis_data_tdata  (m_axis_data_tdata)
   );

   always #10 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Golden model: direct-form convolution over the bench's own history, Q15 round and clamp.
   function automatic logic [15:0] model_step(input logic [15:0] s);
      longint acc;
      longint r;
      for (int k = NT-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      acc = 0;
      for (int k = 0; k < NT; k++) acc += longint'(COEF[k]) * longint'(hist[k]);
      r = (acc + 64'sd16384) >>> 15;
      if (r > 64'sd32767) return 16'h7FFF;
      if (r < -64'sd32768) return 16'h8000;
      return 16'(r);
   endfunction

   task automatic send(input logic [15:0] s);
      int g = 0;
      @(negedge aclk);
      while (!s_axis_data_tready && g < 200) begin
         @(negedge aclk);
         g++;
      end
      if (g >= 200) check("tready_timeout", 32'(s_axis_data_tready), 32'd1);
      s_axis_data_tvalid = 1'b1;
      s_axis_data_tdata  = s;
      sb.push_back('{data: model_step(s), edge_n: cyc + 1});
      @(negedge aclk);
      s_axis_data_tvalid = 1'b0;
   endtask

   task automatic wait_out(output logic [15:0] o);
      int g = 0;
      o = '0;
      while (g < 4*NT) begin
         @(negedge aclk);
         if (m_axis_data_tvalid) begin
            o = m_axis_data_tdata;
            break;
         end
         g++;
      end
      if (g >= 4*NT) check("out_timeout", 32'(m_axis_data_tvalid), 32'd1);
   endtask

   // Output monitor: scoreboard compare, latency, single-cycle pulse, hold between pulses.
   initial begin : monitor
      logic [15:0] last;
      logic        prev_v;
      exp_t        e;
      last   = '0;
      prev_v = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            last   = m_axis_data_tdata;
            prev_v = 1'b0;
         end else if (m_axis_data_tvalid) begin
            check("pulse_width", 32'(prev_v), 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_out", 32'(m_axis_data_tvalid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_data", 32'(m_axis_data_tdata), 32'(e.data));
               check("latency", 32'(cyc - e.edge_n), 32'(NT + 1));
            end
            last   = m_axis_data_tdata;
            prev_v = 1'b1;
         end else begin
            check("hold", 32'(m_axis_data_tdata), 32'(last));
            prev_v = 1'b0;
         end
      end
   end

   initial begin : stim
      logic [15:0] o;
      logic [15:0] e16;
      logic [15:0] s;
      int          accepted;
      int          last_acc;
      int          g;

      for (int k = 0; k < NT; k++) hist[k] = '0;
      areset             = 1'b1;
      s_axis_data_tvalid = 1'b0;
      s_axis_data_tdata  = '0;
      repeat (3) @(negedge aclk);
      check("rst_tready", 32'(s_axis_data_tready), 32'd1);
      check("rst_mvalid", 32'(m_axis_data_tvalid), 32'd0);
      check("rst_mdata",  32'(m_axis_data_tdata),  32'd0);
      areset = 1'b0;

      // Build some history, then abort a computation mid-MAC.
      send(16'h4000);
      send(16'h7FFF);
      send(16'h2345);
      repeat (10) @(negedge aclk);
      @(posedge aclk);
      #3 areset = 1'b1;
      #1;
      check("midmac_tready", 32'(s_axis_data_tready), 32'd1);
      check("midmac_mvalid", 32'(m_axis_data_tvalid), 32'd0);
      check("midmac_mdata",  32'(m_axis_data_tdata),  32'd0);
      sb.delete();
      for (int k = 0; k < NT; k++) hist[k] = '0;
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      repeat (3) @(negedge aclk);
      check("no_pulse_after_abort", 32'(sb.size()), 32'd0);

      // Impulse at audio-rate spacing: response reproduces the taps, then zeros.
      for (int n = 0; n < NT + 5; n++) begin
         send((n == 0) ? 16'h7FFF : 16'h0000);
         wait_out(o);
         e16 = (n < NT) ? COEF[n] : 16'h0000;
         check("impulse", 32'(o), 32'(e16));
         repeat (1133 - NT - 4) @(negedge aclk);
      end

      // DC step: unity gain once the delay line is full.
      for (int i = 0; i < 2*NT; i++) begin
         send(16'h1000);
         wait_out(o);
         if (i >= NT - 1) check("dc_settle", 32'((o >= 16'h0FFF) && (o <= 16'h1001)), 32'd1);
      end

      // Sign-matched full-scale pattern drives the sum past both rails.
      for (int j = 0; j < NT; j++) begin
         send((COEF[NT-1-j] > 0) ? 16'h7FFF : 16'h8000);
         wait_out(o);
      end
      check("sat_pos", 32'(o), 32'h7FFF);
      for (int j = 0; j < NT; j++) begin
         send((COEF[NT-1-j] > 0) ? 16'h8000 : 16'h7FFF);
         wait_out(o);
      end
      check("sat_neg", 32'(o), 32'h8000);

      // tvalid held high with fresh data every cycle: only idle-cycle samples are taken.
      accepted = 0;
      last_acc = -1;
      g        = 0;
      @(negedge aclk);
      s_axis_data_tvalid = 1'b1;
      while (accepted < 1000 && g < 1000*(NT+2) + 100) begin
         if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
         else s = 16'($urandom);
         s_axis_data_tdata = s;
         if (s_axis_data_tready) begin
            sb.push_back('{data: model_step(s), edge_n: cyc + 1});
            if (last_acc >= 0) check("accept_spacing", 32'(cyc + 1 - last_acc), 32'(NT + 2));
            last_acc = cyc + 1;
            accepted++;
         end
         @(negedge aclk);
         g++;
      end
      s_axis_data_tvalid = 1'b0;
      check("accepted_count", 32'(accepted), 32'd1000);

      g = 0;
      while (sb.size() != 0 && g < 4*NT) begin
         @(negedge aclk);
         g++;
      end
      check("drain", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
